pipe_stage_regs: RTL and testbench

//  Consumer end of the hazard-stall interface: the F/D/E/M/W pipeline register bank.
//  - Honours stallPC/stallID/flushEX from the hazard unit.
//  - Generates the A3_x / Tnew_x stage tags that the hazard unit consumes.
//  - Position: sits between the datapath stage logic and the hazard unit.
//  - Also keeps stall/retire performance counters and a sticky protocol-error flag.

---
 rtl/pipe_stage_regs_if.sv | 40 ++++
 rtl/pipe_stage_regs.sv | 74 +++++++
 tb/tb_pipe_stage_regs.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_regs_if.sv
// rtl/pipe_stage_regs_if.sv - hazard/datapath signal bundle for the pipeline register bank
interface pipe_stage_regs_if #(
  parameter int CNT_W = 32
);
  logic             stallPC;
  logic             stallID;
  logic             flushEX;
  logic [31:0]      npc;
  logic [31:0]      instr_F;
  logic [4:0]       A3_D;
  logic [1:0]       Tnew_D;
  logic [31:0]      PC_F;
  logic [31:0]      PC_D;
  logic [31:0]      Instr_D;
  logic [31:0]      PC_E;
  logic [31:0]      PC_M;
  logic [4:0]       A3_E;
  logic [4:0]       A3_M;
  logic [4:0]       A3_W;
  logic [1:0]       Tnew_E;
  logic [1:0]       Tnew_M;
  logic             valid_E;
  logic             valid_M;
  logic             valid_W;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] retire_cnt;
  logic             protocol_err;

  modport master (
    output stallPC, stallID, flushEX, npc, instr_F, A3_D, Tnew_D,
    input  PC_F, PC_D, Instr_D, PC_E, PC_M, A3_E, A3_M, A3_W, Tnew_E, Tnew_M,
    input  valid_E, valid_M, valid_W, stall_cnt, retire_cnt, protocol_err
  );

  modport slave (
    input  stallPC, stallID, flushEX, npc, instr_F, A3_D, Tnew_D,
    output PC_F, PC_D, Instr_D, PC_E, PC_M, A3_E, A3_M, A3_W, Tnew_E, Tnew_M,
    output valid_E, valid_M, valid_W, stall_cnt, retire_cnt, protocol_err
  );
endinterface

// File: rtl/pipe_stage_regs.sv
// rtl/pipe_stage_regs.sv - F/D/E/M/W pipeline register bank with stall/flush, stage tags and counters
module pipe_stage_regs #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int          CNT_W    = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  pipe_stage_regs_if.slave      bus
);

  logic valid_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.PC_F         <= PC_RESET;
      bus.PC_D         <= '0;
      bus.Instr_D      <= '0;
      valid_d          <= 1'b0;
      bus.PC_E         <= '0;
      bus.A3_E         <= '0;
      bus.Tnew_E       <= '0;
      bus.valid_E      <= 1'b0;
      bus.PC_M         <= '0;
      bus.A3_M         <= '0;
      bus.Tnew_M       <= '0;
      bus.valid_M      <= 1'b0;
      bus.A3_W         <= '0;
      bus.valid_W      <= 1'b0;
      bus.stall_cnt    <= '0;
      bus.retire_cnt   <= '0;
      bus.protocol_err <= 1'b0;
    end else begin
      if (!bus.stallPC)
        bus.PC_F <= bus.npc;

      if (!bus.stallID) begin
        bus.PC_D    <= bus.PC_F;
        bus.Instr_D <= bus.instr_F;
        valid_d     <= 1'b1;
      end

      // A write to $0 is architecturally void, so it never advertises a pending result.
      if (bus.flushEX) begin
        bus.PC_E    <= '0;
        bus.A3_E    <= '0;
        bus.Tnew_E  <= '0;
        bus.valid_E <= 1'b0;
      end else begin
        bus.PC_E    <= bus.PC_D;
        bus.A3_E    <= bus.A3_D;
        bus.Tnew_E  <= (bus.A3_D == 5'd0) ? 2'd0 : bus.Tnew_D;
        bus.valid_E <= valid_d;
      end

      bus.PC_M    <= bus.PC_E;
      bus.A3_M    <= bus.A3_E;
      bus.Tnew_M  <= (bus.Tnew_E == 2'd0) ? 2'd0 : bus.Tnew_E - 2'd1;
      bus.valid_M <= bus.valid_E;

      bus.A3_W    <= bus.A3_M;
      bus.valid_W <= bus.valid_M;

      if ((bus.stallPC != bus.stallID) || (bus.stallID != bus.flushEX))
        bus.protocol_err <= 1'b1;

      if (bus.stallPC && (bus.stall_cnt != {CNT_W{1'b1}}))
        bus.stall_cnt <= bus.stall_cnt + 1'b1;

      if (bus.valid_W && (bus.retire_cnt != {CNT_W{1'b1}}))
        bus.retire_cnt <= bus.retire_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_regs.sv
// tb/tb_pipe_stage_regs.sv - directed self-checking bench for pipe_stage_regs
module tb_pipe_stage_regs;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_failed;

  pipe_stage_regs_if #(.CNT_W(32)) bus ();

  pipe_stage_regs #(.PC_RESET(32'h0000_3000), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] pc);
    bus.npc     = pc + 32'd4;
    bus.instr_F = {16'hA000, pc[15:0]};
  endtask

  task automatic stall(input logic s_pc, input logic s_id, input logic f_ex);
    bus.stallPC = s_pc;
    bus.stallID = s_id;
    bus.flushEX = f_ex;
  endtask

  task automatic dest(input logic [4:0] a3, input logic [1:0] tn);
    bus.A3_D   = a3;
    bus.Tnew_D = tn;
  endtask

  initial begin
    n_tests  = 0;
    n_failed = 0;
    reset    = 1'b0;
    stall(0, 0, 0);
    dest(5'd0, 2'd0);
    fetch(32'h0000_3000);

    tick(); tick();
    check("rst_pc_f",     bus.PC_F, 32'h0000_3000);
    check("rst_a3_e",     {27'd0, bus.A3_E}, 32'd0);
    check("rst_a3_w",     {27'd0, bus.A3_W}, 32'd0);
    check("rst_valids",   {29'd0, bus.valid_E, bus.valid_M, bus.valid_W}, 32'd0);
    check("rst_stall",    bus.stall_cnt, 32'd0);
    check("rst_retire",   bus.retire_cnt, 32'd0);
    check("rst_perr",     {31'd0, bus.protocol_err}, 32'd0);

    reset = 1'b1;
    dest(5'd5, 2'd2);
    tick();                                      // E1
    check("e1_pc_f",      bus.PC_F, 32'h0000_3004);
    check("e1_pc_d",      bus.PC_D, 32'h0000_3000);
    check("e1_a3_e",      {27'd0, bus.A3_E}, 32'd5);
    check("e1_tnew_e",    {30'd0, bus.Tnew_E}, 32'd2);
    check("e1_valid_e",   {31'd0, bus.valid_E}, 32'd0);

    fetch(32'h0000_3004); dest(5'd0, 2'd2);
    tick();                                      // E2
    check("e2_pc_f",      bus.PC_F, 32'h0000_3008);
    check("e2_a3_e_zero", {27'd0, bus.A3_E}, 32'd0);
    check("e2_tnew_e_r0", {30'd0, bus.Tnew_E}, 32'd0);
    check("e2_a3_m",      {27'd0, bus.A3_M}, 32'd5);
    check("e2_tnew_m",    {30'd0, bus.Tnew_M}, 32'd1);
    check("e2_valid_e",   {31'd0, bus.valid_E}, 32'd1);

    fetch(32'h0000_3008); dest(5'd7, 2'd1);
    tick();                                      // E3
    check("e3_tnew_m_nowrap", {30'd0, bus.Tnew_M}, 32'd0);
    check("e3_a3_w",      {27'd0, bus.A3_W}, 32'd5);
    check("e3_tnew_e",    {30'd0, bus.Tnew_E}, 32'd1);

    fetch(32'h0000_300C); dest(5'd9, 2'd3);
    tick();                                      // E4
    check("e4_a3_m",      {27'd0, bus.A3_M}, 32'd7);
    check("e4_tnew_m",    {30'd0, bus.Tnew_M}, 32'd0);
    check("e4_tnew_e",    {30'd0, bus.Tnew_E}, 32'd3);
    check("e4_valid_w",   {31'd0, bus.valid_W}, 32'd1);
    check("e4_retire",    bus.retire_cnt, 32'd0);

    fetch(32'h0000_3010); dest(5'd10, 2'd2);
    tick();                                      // E5
    check("e5_pc_f",      bus.PC_F, 32'h0000_3014);
    check("e5_instr_d",   bus.Instr_D, 32'hA000_3010);
    check("e5_tnew_m",    {30'd0, bus.Tnew_M}, 32'd2);
    check("e5_retire",    bus.retire_cnt, 32'd1);

    // load-use stall: F and D hold, bubble into E, E drains to M
    stall(1, 1, 1); dest(5'd11, 2'd1);
    bus.npc = 32'hDEAD_0000; bus.instr_F = 32'hBAD0_0000;
    tick();                                      // E6
    check("ld_pc_f_hold", bus.PC_F, 32'h0000_3014);
    check("ld_pc_d_hold", bus.PC_D, 32'h0000_3010);
    check("ld_instr_d",   bus.Instr_D, 32'hA000_3010);
    check("ld_a3_e",      {27'd0, bus.A3_E}, 32'd0);
    check("ld_valid_e",   {31'd0, bus.valid_E}, 32'd0);
    check("ld_pc_e",      bus.PC_E, 32'd0);
    check("ld_a3_m",      {27'd0, bus.A3_M}, 32'd10);
    check("ld_tnew_m",    {30'd0, bus.Tnew_M}, 32'd1);
    check("ld_pc_m",      bus.PC_M, 32'h0000_300C);
    check("ld_stall_cnt", bus.stall_cnt, 32'd1);
    check("ld_perr",      {31'd0, bus.protocol_err}, 32'd0);
    check("ld_retire",    bus.retire_cnt, 32'd2);

    stall(0, 0, 0); fetch(32'h0000_3014);
    tick();                                      // E7
    check("e7_pc_f",      bus.PC_F, 32'h0000_3018);
    check("e7_pc_d",      bus.PC_D, 32'h0000_3014);
    check("e7_a3_e",      {27'd0, bus.A3_E}, 32'd11);
    check("e7_valid_m",   {31'd0, bus.valid_M}, 32'd0);
    check("e7_a3_w",      {27'd0, bus.A3_W}, 32'd10);
    check("e7_retire",    bus.retire_cnt, 32'd3);

    fetch(32'h0000_3018);
    tick();                                      // E8
    check("e8_valid_w",   {31'd0, bus.valid_W}, 32'd0);
    check("e8_retire",    bus.retire_cnt, 32'd4);

    fetch(32'h0000_301C);
    tick();                                      // E9
    check("e9_bubble_no_retire", bus.retire_cnt, 32'd4);

    // stallPC alone: protocol error, F still obeys stallPC
    stall(1, 0, 0); bus.npc = 32'hDEAD_0004;
    tick();                                      // E10
    check("pe_set",       {31'd0, bus.protocol_err}, 32'd1);
    check("pe_pc_hold",   bus.PC_F, 32'h0000_3020);
    check("pe_stall_cnt", bus.stall_cnt, 32'd2);

    stall(0, 0, 0); fetch(32'h0000_3020);
    tick();                                      // E11
    check("pe_sticky",    {31'd0, bus.protocol_err}, 32'd1);
    check("e11_pc_f",     bus.PC_F, 32'h0000_3024);

    stall(1, 1, 1); bus.npc = 32'hDEAD_0008;
    tick(); tick();                              // E12, E13
    check("st2_stall_cnt", bus.stall_cnt, 32'd4);
    check("st2_pc_hold",  bus.PC_F, 32'h0000_3024);
    check("st2_valid_e",  {31'd0, bus.valid_E}, 32'd0);

    reset = 1'b0;
    tick();                                      // E14: reset during stall
    check("rs_pc_f",      bus.PC_F, 32'h0000_3000);
    check("rs_pc_d",      bus.PC_D, 32'd0);
    check("rs_instr_d",   bus.Instr_D, 32'd0);
    check("rs_a3_m",      {27'd0, bus.A3_M}, 32'd0);
    check("rs_valids",    {29'd0, bus.valid_E, bus.valid_M, bus.valid_W}, 32'd0);
    check("rs_stall_cnt", bus.stall_cnt, 32'd0);
    check("rs_retire",    bus.retire_cnt, 32'd0);
    check("rs_perr",      {31'd0, bus.protocol_err}, 32'd0);

    reset = 1'b1; stall(0, 0, 0); fetch(32'h0000_3000);
    tick();
    check("post_rs_pc_f", bus.PC_F, 32'h0000_3004);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
